// File: rtl/intp_pkg.sv
// Shared definitions for the interrupt service master: FSM encoding,
// default bus widths and the service counter width.
package intp_pkg;

   localparam int DEF_ADDR_WIDTH  = 4;
   localparam int DEF_DATA_WIDTH  = 4;
   localparam int SERVICE_COUNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_ACCESS   = 3'd2,
      ST_CFG_DONE = 3'd3,
      ST_SERVICE  = 3'd4,
      ST_SERVICED = 3'd5,
      ST_GUARD    = 3'd6
   } state_e;

   // Terminal value of an 8-bit cycle counter that must run for n cycles.
   function automatic logic [7:0] last_count(input int n);
      return 8'(n - 1);
   endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB initiator datapath: holds the request fields for the duration of a
// transfer, drives the bus phases requested by the top-level FSM, runs the
// ACCESS wait/timeout counter and captures the completion status.
module apb_master_if
   import intp_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                  pclk_i,
   input  logic                  prst_n_i,
   input  logic                  start_i,
   input  logic                  write_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  setup_i,
   input  logic                  access_i,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   input  logic [DATA_WIDTH-1:0] prdata_i,
   input  logic                  pready_i,
   input  logic                  perror_i,
   output logic                  done_o,
   output logic                  err_o,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam logic [7:0] TO_LAST = last_count(TIMEOUT_CYCLES);

   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [7:0]            wait_cnt_q, wait_cnt_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  timeout;

   // Bus phase decode, timeout detect and next-state of the held request/status.
   always_comb begin
      write_d    = write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      wait_cnt_d = access_i ? (wait_cnt_q + 8'd1) : 8'd0;
      timeout    = access_i && !pready_i && (wait_cnt_q == TO_LAST);
      done_o     = access_i && (pready_i || timeout);
      if (start_i) begin
         write_d = write_i;
         addr_d  = addr_i;
         wdata_d = wdata_i;
      end
      if (done_o) begin
         // A timed-out transfer reports an error and never returns bus data.
         err_d   = pready_i ? perror_i : 1'b1;
         rdata_d = (pready_i && !write_q) ? prdata_i : '0;
      end
   end

   // Request and status registers.
   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) begin
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wait_cnt_q <= 8'd0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         write_q    <= write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end

   assign psel_o    = setup_i | access_i;
   assign penable_o = access_i;
   assign pwrite_o  = write_q;
   assign paddr_o   = addr_q;
   assign pwdata_o  = wdata_q;
   assign err_o     = err_q;
   assign rdata_o   = rdata_q;

endmodule

// File: rtl/intp_service_master.sv
// Processor-side master: arbitrates between host configuration requests
// (carried out as APB transfers) and interrupt service windows, with
// interrupts taking priority whenever both are pending in IDLE.
module intp_service_master
   import intp_pkg::*;
#(
   parameter int NUM_OF_PERIPHERALS = 16,
   parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
   parameter int SERVICE_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES     = 8
) (
   input  logic                       pclk_i,
   input  logic                       prst_n_i,
   input  logic                       cfg_req_i,
   output logic                       cfg_ready_o,
   input  logic                       cfg_write_i,
   input  logic [ADDR_WIDTH-1:0]      cfg_addr_i,
   input  logic [DATA_WIDTH-1:0]      cfg_wdata_i,
   output logic                       cfg_ack_o,
   output logic [DATA_WIDTH-1:0]      cfg_rdata_o,
   output logic                       cfg_err_o,
   output logic                       psel_o,
   output logic                       penable_o,
   output logic                       pwrite_o,
   output logic [ADDR_WIDTH-1:0]      paddr_o,
   output logic [DATA_WIDTH-1:0]      pwdata_o,
   input  logic [DATA_WIDTH-1:0]      prdata_i,
   input  logic                       pready_i,
   input  logic                       perror_i,
   input  logic                       intp_valid_i,
   input  logic [DATA_WIDTH-1:0]      intp_to_service_i,
   output logic                       intp_serviced_o,
   output logic [DATA_WIDTH-1:0]      serviced_id_o,
   output logic [SERVICE_COUNT_W-1:0] service_count_o
);

   if (NUM_OF_PERIPHERALS > (1 << ADDR_WIDTH)) begin : g_bad_addr_width
      $error("ADDR_WIDTH too small for NUM_OF_PERIPHERALS");
   end

   localparam logic [7:0] SVC_LAST = last_count(SERVICE_CYCLES);

   state_e                     state_q, state_d;
   logic                       live_q, live_d;
   logic [7:0]                 svc_cnt_q, svc_cnt_d;
   logic [DATA_WIDTH-1:0]      id_q, id_d;
   logic [DATA_WIDTH-1:0]      serviced_id_q, serviced_id_d;
   logic [SERVICE_COUNT_W-1:0] service_count_q, service_count_d;
   logic                       apb_start;
   logic                       apb_done;
   logic                       idle_ready;

   // Arbitration, APB phase sequencing and interrupt service timing.
   always_comb begin
      state_d         = state_q;
      live_d          = 1'b1;
      svc_cnt_d       = svc_cnt_q;
      id_d            = id_q;
      serviced_id_d   = serviced_id_q;
      service_count_d = service_count_q;
      apb_start       = 1'b0;
      // live_q keeps the host port closed for the first cycle after reset.
      idle_ready      = live_q && (state_q == ST_IDLE) && !intp_valid_i;
      unique case (state_q)
         ST_IDLE: begin
            if (live_q && intp_valid_i) begin
               id_d      = intp_to_service_i;
               svc_cnt_d = 8'd0;
               state_d   = ST_SERVICE;
            end else if (idle_ready && cfg_req_i) begin
               apb_start = 1'b1;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP:    state_d = ST_ACCESS;
         ST_ACCESS:   if (apb_done) state_d = ST_CFG_DONE;
         ST_CFG_DONE: state_d = ST_IDLE;
         ST_SERVICE: begin
            if (svc_cnt_q == SVC_LAST) begin
               serviced_id_d   = id_q;
               service_count_d = service_count_q + SERVICE_COUNT_W'(1);
               state_d         = ST_SERVICED;
            end else begin
               svc_cnt_d = svc_cnt_q + 8'd1;
            end
         end
         ST_SERVICED: state_d = ST_GUARD;
         // One dead cycle so the controller can drop intp_valid_i.
         ST_GUARD:    state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // FSM state, service counter and service bookkeeping registers.
   always_ff @(posedge pclk_i or negedge prst_n_i) begin
      if (!prst_n_i) begin
         state_q         <= ST_IDLE;
         live_q          <= 1'b0;
         svc_cnt_q       <= 8'd0;
         id_q            <= '0;
         serviced_id_q   <= '0;
         service_count_q <= '0;
      end else begin
         state_q         <= state_d;
         live_q          <= live_d;
         svc_cnt_q       <= svc_cnt_d;
         id_q            <= id_d;
         serviced_id_q   <= serviced_id_d;
         service_count_q <= service_count_d;
      end
   end

   apb_master_if #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_apb (
      .pclk_i    (pclk_i),
      .prst_n_i  (prst_n_i),
      .start_i   (apb_start),
      .write_i   (cfg_write_i),
      .addr_i    (cfg_addr_i),
      .wdata_i   (cfg_wdata_i),
      .setup_i   (state_q == ST_SETUP),
      .access_i  (state_q == ST_ACCESS),
      .psel_o    (psel_o),
      .penable_o (penable_o),
      .pwrite_o  (pwrite_o),
      .paddr_o   (paddr_o),
      .pwdata_o  (pwdata_o),
      .prdata_i  (prdata_i),
      .pready_i  (pready_i),
      .perror_i  (perror_i),
      .done_o    (apb_done),
      .err_o     (cfg_err_o),
      .rdata_o   (cfg_rdata_o)
   );

   assign cfg_ready_o     = idle_ready;
   assign cfg_ack_o       = (state_q == ST_CFG_DONE);
   assign intp_serviced_o = (state_q == ST_SERVICED);
   assign serviced_id_o   = serviced_id_q;
   assign service_count_o = service_count_q;

endmodule
